mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the RV32I core, between execute and `write_stage`. It performs loads and stores against a single-port data memory using a req/ack handshake, stalls the upstream pipeline while an access is pending, and registers the MEM/WB pipeline values. Load data is lane-aligned: the addressed byte or halfword is shifted to bit 0, so the write stage applies only sign or zero extension.

## Interface
- No parameters. `NOP = 32'h0000_0013` (addi x0,x0,0) is a fixed localparam.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_mem` in 32: instruction in MEM. Held stable by upstream while `mem_stall` is high.
- `valid_mem` in 1: `instr_mem` is a real instruction (0 = bubble).
- `alu_result_in` in 32: ALU result; the effective address for loads and stores.
- `rs2_data` in 32: store source data.
- `mem_stall` out 1: upstream freeze request (combinational).
- `dmem_req` out 1: memory request, registered.
- `dmem_we` out 1: 1 = store, registered.
- `dmem_addr` out 32: word address `{addr[31:2],2'b00}`, registered.
- `dmem_wdata` out 32: lane-replicated store data, registered.
- `dmem_wstrb` out 4: byte strobes, registered; 0 for loads.
- `dmem_rdata` in 32: read word, valid in the same cycle as `dmem_ack`.
- `dmem_ack` in 1: access complete (single-cycle pulse).
- `instr_wb` out 32: instruction to WB, registered.
- `alu_result` out 32: ALU result to WB, registered.
- `mem_data_out` out 32: lane-aligned load data, registered; 0 for non-loads.
- `misaligned` out 1: one-cycle registered pulse marking a dropped misaligned access.

## Operation
- **Decode.** Load is opcode `0000011` with funct3 ∈ {000, 001, 010, 100, 101}. Store is opcode `0100011` with funct3 ∈ {000, 001, 010}. Any other funct3 under these opcodes is treated as a bubble (no access, no flag).
- **Alignment.** An access is misaligned if it is a halfword with `addr[0]=1`, or a word with `addr[1:0]≠0`. Misaligned accesses never touch memory. WB receives `NOP`, and `misaligned` pulses.
- **FSM states:** IDLE, ACCESS.
  - IDLE → ACCESS: on a rising edge with `valid_mem` high and an aligned load or store present. At that edge the request registers are loaded.
  - In ACCESS, `dmem_req=1` and all `dmem_*` outputs are held constant.
  - ACCESS → IDLE: on the edge where `dmem_ack=1`.
- **Stall.** `mem_stall = (IDLE & valid_mem & aligned mem op) | (ACCESS & ~dmem_ack)`.
- **Store lanes**, with `s=addr[1:0]`:
  - sb: wdata `{4{rs2[7:0]}}`, wstrb `4'b0001<<s`.
  - sh: wdata `{2{rs2[15:0]}}`, wstrb `4'b0011<<s`.
  - sw: wdata `rs2`, wstrb `4'b1111`.
- **Load alignment.** `mem_data_out = dmem_rdata >> (8*addr[1:0])`, captured at the ack edge. The address used is the one latched at request time.
- **WB register update, per rising edge:**
  - IDLE, non-memory valid instruction: `instr_wb=instr_mem`, `alu_result=alu_result_in`, `mem_data_out=0`.
  - IDLE with `valid_mem=0`: `instr_wb=NOP`, `alu_result=0`, `mem_data_out=0`.
  - IDLE, entering ACCESS: `instr_wb=NOP` (bubble).
  - ACCESS without ack: `instr_wb=NOP`.
  - ACCESS with ack: `instr_wb`, `alu_result` from the latched request; `mem_data_out` = aligned `dmem_rdata` for loads, 0 for stores.
  - Misaligned: `instr_wb=NOP`, `misaligned=1` for one cycle.

## Timing
- **Reset values:**
  - State IDLE.
  - `dmem_req=0`, `dmem_we=0`, `dmem_addr=0`, `dmem_wdata=0`, `dmem_wstrb=0`.
  - `instr_wb=NOP`, `alu_result=0`, `mem_data_out=0`, `misaligned=0`.
- **Reset mid-access.** `dmem_req` deasserts immediately, and a subsequent ack is ignored.
- **Non-memory latency:** 1 cycle, no stall.
- **Memory-op latency:**
  - The operation is accepted at edge T, and `dmem_req` is high from T.
  - If ack is sampled at edge T+k (k≥1), WB sees the result after T+k.
  - `mem_stall` is high from the cycle before T until the ack cycle. Upstream advances at edge T+k.
- **Ack in IDLE:** ignored.
- **Back-to-back memory ops:** the next op sees IDLE after T+k and issues at T+k+1. There is a minimum of one bubble between accesses.
- **Misaligned op:** no stall; handled in 1 cycle like a non-memory instruction.

## Test plan
- **ALU passthrough.** add, `alu_result_in=0x1234`, no memory → after 1 edge: `instr_wb=instr`, `alu_result=0x1234`, `mem_data_out=0`, `mem_stall` never high.
- **lb.** lb at addr `0x1003`, memory returns `0xAB112233` after 3 wait cycles → `dmem_addr=0x1000` and `wstrb=0` during the request, `mem_stall` high for 4 cycles, then `mem_data_out=0x000000AB`.
- **sh.** sh at addr `0x2002`, `rs2=0xDEADBEEF` → `dmem_we=1`, `wdata=0xBEEFBEEF`, `wstrb=4'b1100`, `mem_data_out=0` after ack.
- **Misaligned.** lw at `0x3001` → `dmem_req` stays 0, `misaligned` pulses 1 cycle, `instr_wb=NOP`, no stall.
- **Back-to-back.** sw then lw, each acked after 1 cycle → two separate requests with a 1-cycle gap. `dmem_*` is stable while `req` is high.
- **Reset mid-access.** Assert `rst` while in ACCESS, then ack 2 cycles later → `dmem_req=0` immediately, ack ignored, WB outputs at reset values.

Source files
------------

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : RV32I memory-access stage. Issues loads/stores over a req/ack
//             port, stalls upstream while pending, registers MEM/WB values.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_mem,
  input  logic        valid_mem,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_data,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] instr_wb,
  output logic [31:0] alu_result,
  output logic [31:0] mem_data_out,
  output logic        misaligned
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [0:0]  IDLE     = 1'b0;
  localparam logic [0:0]  ACCESS   = 1'b1;

  logic [0:0]  state, state_next;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic        is_load, is_store, mem_opcode, mem_op, addr_bad;
  logic        start, drop;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] req_instr, req_alu;
  logic [1:0]  req_lo;
  logic        req_load;

  assign opcode     = instr_mem[6:0];
  assign funct3     = instr_mem[14:12];
  assign addr_lo    = alu_result_in[1:0];
  assign mem_opcode = (opcode == OP_LOAD) || (opcode == OP_STORE);

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    if (opcode == OP_LOAD) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_load = 1'b1;
        default: is_load = 1'b0;
      endcase
    end
    if (opcode == OP_STORE) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: is_store = 1'b1;
        default: is_store = 1'b0;
      endcase
    end
  end

  assign addr_bad = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  assign mem_op   = valid_mem && (is_load || is_store);
  assign start    = (state == IDLE) && mem_op && !addr_bad;
  assign drop     = (state == IDLE) && mem_op && addr_bad;

  // Store data is replicated across lanes; strobes select the addressed bytes.
  always_comb begin
    st_wdata = 32'h0;
    st_wstrb = 4'h0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          st_wdata = {4{rs2_data[7:0]}};
          st_wstrb = 4'b0001 << addr_lo;
        end
        2'b01: begin
          st_wdata = {2{rs2_data[15:0]}};
          st_wstrb = 4'b0011 << addr_lo;
        end
        default: begin
          st_wdata = rs2_data;
          st_wstrb = 4'b1111;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)    state_next = ACCESS;
      ACCESS:  if (dmem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    case (state)
      IDLE:    mem_stall = start;
      ACCESS:  mem_stall = !dmem_ack;
      default: mem_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'h0;
      dmem_wdata   <= 32'h0;
      dmem_wstrb   <= 4'h0;
      req_instr    <= NOP;
      req_alu      <= 32'h0;
      req_lo       <= 2'b00;
      req_load     <= 1'b0;
      instr_wb     <= NOP;
      alu_result   <= 32'h0;
      mem_data_out <= 32'h0;
      misaligned   <= 1'b0;
    end else begin
      misaligned <= drop;
      if (state == IDLE) begin
        if (start) begin
          dmem_req     <= 1'b1;
          dmem_we      <= is_store;
          dmem_addr    <= {alu_result_in[31:2], 2'b00};
          dmem_wdata   <= st_wdata;
          dmem_wstrb   <= st_wstrb;
          req_instr    <= instr_mem;
          req_alu      <= alu_result_in;
          req_lo       <= addr_lo;
          req_load     <= is_load;
          instr_wb     <= NOP;
          alu_result   <= 32'h0;
          mem_data_out <= 32'h0;
        end else if (valid_mem && !mem_opcode) begin
          instr_wb     <= instr_mem;
          alu_result   <= alu_result_in;
          mem_data_out <= 32'h0;
        end else begin
          // bubbles, unknown mem funct3 and dropped misaligned ops
          instr_wb     <= NOP;
          alu_result   <= 32'h0;
          mem_data_out <= 32'h0;
        end
      end else if (dmem_ack) begin
        dmem_req     <= 1'b0;
        instr_wb     <= req_instr;
        alu_result   <= req_alu;
        mem_data_out <= req_load ? (dmem_rdata >> {req_lo, 3'b000}) : 32'h0;
      end else begin
        instr_wb     <= NOP;
        alu_result   <= 32'h0;
        mem_data_out <= 32'h0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : randomized scoreboard bench for mem_stage with a byte-level
//                memory model and a req/ack responder.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_mem, alu_result_in, rs2_data;
  logic        valid_mem;
  logic        mem_stall, dmem_req, dmem_we, dmem_ack, misaligned;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] instr_wb, alu_result, mem_data_out;

  mem_stage dut (
    .clk(clk), .rst(rst), .instr_mem(instr_mem), .valid_mem(valid_mem),
    .alu_result_in(alu_result_in), .rs2_data(rs2_data), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .instr_wb(instr_wb), .alu_result(alu_result),
    .mem_data_out(mem_data_out), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [31:0] alu; logic [31:0] mdo; logic mis; } wb_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  logic [7:0] mem_b [0:255];
  int compared = 0;
  int mismatched = 0;
  int last_k = 0;
  int force_wait = -1;
  logic resp_en = 1'b1;
  logic spur_ack = 1'b0;
  logic abort = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_b[a[7:0] + 8'd3], mem_b[a[7:0] + 8'd2], mem_b[a[7:0] + 8'd1], mem_b[a[7:0]]};
  endfunction

  // Memory responder: checks each request, holds it for a random wait, then acks.
  initial begin
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      if (spur_ack) begin
        dmem_ack = 1'b1;
        spur_ack = 1'b0;
        continue;
      end
      if (!resp_en || !dmem_req) continue;
      begin
        req_t cur;
        int w;
        cur = '{dmem_we, dmem_addr, dmem_wdata, dmem_wstrb};
        if (req_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_req: got addr %h expected no request", dmem_addr);
        end else begin
          req_t e;
          e = req_q.pop_front();
          check("req_we", {31'h0, dmem_we}, {31'h0, e.we});
          check("req_addr", dmem_addr, e.addr);
          check("req_wstrb", {28'h0, dmem_wstrb}, {28'h0, e.wstrb});
          if (e.we) check("req_wdata", dmem_wdata, e.wdata);
        end
        w = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
        last_k = w + 1;
        for (int i = 0; i <= w; i++) begin
          if (i > 0) @(negedge clk);
          check("req_hold", {dmem_req, dmem_we, dmem_wstrb, dmem_addr ^ dmem_wdata},
                {1'b1, cur.we, cur.wstrb, cur.addr ^ cur.wdata});
        end
        dmem_rdata = mem_word(dmem_addr);
        dmem_ack = 1'b1;
      end
    end
  end

  // WB monitor: any non-NOP instruction or misaligned flag is a presented result.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) continue;
      if (instr_wb !== NOP || misaligned !== 1'b0) begin
        if (wb_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_wb: got instr %h mis %b expected nothing", instr_wb, misaligned);
        end else begin
          wb_t e;
          e = wb_q.pop_front();
          check("wb_instr", instr_wb, e.instr);
          check("wb_misaligned", {31'h0, misaligned}, {31'h0, e.mis});
          if (!e.mis) begin
            check("wb_alu", alu_result, e.alu);
            check("wb_mem_data", mem_data_out, e.mdo);
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rs2);
    logic [6:0] op;
    logic [2:0] f3;
    int nbytes, s, stalls;
    logic ld, st, mis;
    op = ins[6:0];
    f3 = ins[14:12];
    ld = (op == 7'b0000011) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    st = (op == 7'b0100011) && (f3 inside {3'd0, 3'd1, 3'd2});
    nbytes = 1 << f3[1:0];
    s = int'(alu[1:0]);
    mis = (ld || st) && ((s % nbytes) != 0);
    if (ld || st) begin
      if (mis) wb_q.push_back('{NOP, 32'h0, 32'h0, 1'b1});
      else begin
        req_t r;
        logic [31:0] data;
        r.we = st;
        r.addr = alu & ~32'h3;
        r.wdata = 32'h0;
        r.wstrb = 4'h0;
        data = 32'h0;
        if (st) begin
          for (int i = 0; i < 4; i++) begin
            r.wdata[8*i +: 8] = rs2[8*(i % nbytes) +: 8];
            r.wstrb[i] = (i >= s) && (i < s + nbytes);
          end
          for (int i = 0; i < nbytes; i++) mem_b[alu[7:0] + 8'(i)] = rs2[8*i +: 8];
        end else begin
          for (int i = 0; i < 4 - s; i++) data[8*i +: 8] = mem_b[alu[7:0] + 8'(i)];
        end
        req_q.push_back(r);
        wb_q.push_back('{ins, alu, data, 1'b0});
      end
    end else if (op != 7'b0000011 && op != 7'b0100011) begin
      wb_q.push_back('{ins, alu, 32'h0, 1'b0});
    end
    @(negedge clk);
    instr_mem = ins;
    alu_result_in = alu;
    rs2_data = rs2;
    valid_mem = 1'b1;
    stalls = 0;
    forever begin
      #4;
      if (!mem_stall) break;
      stalls++;
      if (stalls > 50) begin
        compared++;
        mismatched++;
        $display("FAIL stall_timeout: got %0d stalled cycles expected at most 50", stalls);
        abort = 1'b1;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    check("stall_cycles", stalls, ((ld || st) && !mis) ? last_k : 0);
  endtask

  task automatic bubble();
    @(negedge clk);
    valid_mem = 1'b0;
    instr_mem = $urandom;
    alu_result_in = $urandom;
    rs2_data = $urandom;
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] ins, alu;
    int kind;
    rst = 1'b1;
    valid_mem = 1'b0;
    instr_mem = NOP;
    alu_result_in = 32'h0;
    rs2_data = 32'h0;
    for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
    {mem_b[3], mem_b[2], mem_b[1], mem_b[0]} = 32'hAB11_2233;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'h0, dmem_req}, 32'h0);
    check("rst_dmem", {dmem_we, dmem_wstrb, dmem_addr | dmem_wdata}, 37'h0);
    check("rst_instr_wb", instr_wb, NOP);
    check("rst_wb_data", alu_result | mem_data_out, 32'h0);
    check("rst_misaligned", {31'h0, misaligned}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    issue(32'h0020_81B3, 32'h0000_1234, 32'h0);  // add
    force_wait = 3;
    issue(32'h0000_8283, 32'h0000_1003, 32'h0);  // lb, expect 0xAB
    force_wait = -1;
    issue(32'h0020_9023, 32'h0000_2002, 32'hDEAD_BEEF);  // sh
    issue(32'h0000_A283, 32'h0000_3001, 32'h0);  // lw misaligned
    force_wait = 0;
    issue(32'h0020_A023, 32'h0000_1010, 32'h1357_9BDF);  // sw
    issue(32'h0000_A283, 32'h0000_1010, 32'h0);  // lw
    force_wait = -1;

    for (int n = 0; n < 300 && !abort; n++) begin
      kind = int'($urandom_range(0, 9));
      alu = 32'h0000_1000 | 32'($urandom_range(0, 255));
      case (kind)
        0, 1, 2: begin
          ins = {7'($urandom), 10'($urandom), 3'($urandom), 5'($urandom), 7'b0110011};
          alu = $urandom;
        end
        3, 4, 5: begin
          logic [2:0] lf [5];
          lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
          ins = {17'($urandom), lf[$urandom_range(0, 4)], 5'($urandom), 7'b0000011};
        end
        6, 7: ins = {17'($urandom), 3'($urandom_range(0, 2)), 5'($urandom), 7'b0100011};
        8: ins = {17'($urandom), 3'($urandom_range(3, 7)), 5'($urandom),
                  ($urandom_range(0, 1) == 0) ? 7'b0000011 : 7'b0100011};
        default: ins = 32'h0;
      endcase
      if (kind == 9) bubble();
      else issue(ins, alu, $urandom);
    end

    if (!abort) begin
      // reset while a request is outstanding; a later ack must be ignored
      resp_en = 1'b0;
      @(negedge clk);
      instr_mem = 32'h0000_A283;
      alu_result_in = 32'h0000_1020;
      valid_mem = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_req_up", {31'h0, dmem_req}, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      valid_mem = 1'b0;
      #1;
      check("midrst_req_drop", {31'h0, dmem_req}, 32'h0);
      check("midrst_instr_wb", instr_wb, NOP);
      @(negedge clk);
      rst = 1'b0;
      spur_ack = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("spur_ack_req", {31'h0, dmem_req}, 32'h0);
      check("spur_ack_instr_wb", instr_wb, NOP);
      check("spur_ack_wb_data", alu_result | mem_data_out, 32'h0);
      check("spur_ack_stall", {31'h0, mem_stall}, 32'h0);
    end

    repeat (3) @(posedge clk);
    check("wb_queue_drained", wb_q.size(), 0);
    check("req_queue_drained", req_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    mismatched++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
